// File: rtl/alu_arbiter.sv
// Two-port valid/ready arbiter in front of the shared ALU, one-entry response register.
// `define ALU_ARB_RR_EN for round-robin; otherwise fixed priority with port-1 starvation guard.
module alu_arbiter #(
  parameter int WIDTH      = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [2:0]       req0_func3,
  input  logic             req0_subsra,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [2:0]       req1_func3,
  input  logic             req1_subsra,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [2:0]       alu_func3,
  output logic             alu_subsra,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result
);

  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             slot_free, v0, v1, gnt, win;

  // Requests seen during reset are never accepted.
  assign v0        = req0_valid & ~rst;
  assign v1        = req1_valid & ~rst;
  assign slot_free = ~rsp_valid_q | rsp_ready;
  assign gnt       = slot_free & (v0 | v1);

`ifdef ALU_ARB_RR_EN
  logic last_q, last_d;

  always_comb begin
    win    = (v0 & v1) ? ~last_q : v1;
    last_d = gnt ? win : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`else
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  logic [SW-1:0] starve_q, starve_d;

  always_comb begin
    win      = v1 & (~v0 | (starve_q >= STARVE_LIM));
    starve_d = starve_q;
    if (gnt && win)
      starve_d = '0;
    else if (gnt && v1 && starve_q != STARVE_LIM)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`endif

  assign req0_ready = gnt & ~win;
  assign req1_ready = gnt & win;

  always_comb begin
    alu_op1    = req0_op1;
    alu_op2    = req0_op2;
    alu_func3  = req0_func3;
    alu_subsra = req0_subsra;
    if (gnt && win) begin
      alu_op1    = req1_op1;
      alu_op2    = req1_op2;
      alu_func3  = req1_func3;
      alu_subsra = req1_subsra;
    end
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q & ~rsp_ready;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    if (gnt) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = win;
      rsp_result_d = alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

endmodule
